ifu_fetch: RTL and testbench

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch_pkg.sv | 19 +
 rtl/ifu_fetch.sv | 97 +++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit definitions: datapath width, default boot address, FSM encoding.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package ifu_fetch_pkg;
    localparam int CPU_WIDTH = `CPU_WIDTH;
    localparam logic [CPU_WIDTH-1:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] a);
        return {a[CPU_WIDTH-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: single-outstanding request to imem, one-entry hold register to the decoder,
// redirect support with a drop flag for the response already in flight.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_imem_req,
    output logic [CPU_WIDTH-1:0] o_imem_addr,
    input  logic                 i_imem_gnt,
    input  logic                 i_imem_rvalid,
    input  logic [31:0]          i_imem_rdata,
    input  logic                 i_redirect,
    input  logic [CPU_WIDTH-1:0] i_redirect_pc,
    output logic                 o_ins_valid,
    input  logic                 i_ins_ready,
    output logic [31:0]          o_ins,
    output logic [CPU_WIDTH-1:0] o_pc
);
    fetch_state_t         state, state_nxt;
    logic [CPU_WIDTH-1:0] pc, pc_nxt, pc_inc, redirect_tgt, o_pc_nxt;
    logic                 drop, drop_nxt, ins_valid_nxt;
    logic [31:0]          ins_nxt;

    assign pc_inc       = pc + CPU_WIDTH'(4);
    assign redirect_tgt = align_word(i_redirect_pc);
    assign o_imem_req   = (state == S_REQ) && !i_rst;
    assign o_imem_addr  = pc;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        drop_nxt      = drop;
        ins_nxt       = o_ins;
        o_pc_nxt      = o_pc;
        ins_valid_nxt = o_ins_valid;
        case (state)
            S_REQ: begin
                if (i_redirect) pc_nxt = redirect_tgt;
                // A grant in the redirect cycle fetches the stale pc; mark it for discard.
                if (i_imem_gnt) begin
                    state_nxt = S_WAIT;
                    drop_nxt  = i_redirect;
                end
            end
            S_WAIT: begin
                if (i_redirect) pc_nxt = redirect_tgt;
                if (i_imem_rvalid) begin
                    if (drop || i_redirect) begin
                        drop_nxt  = 1'b0;
                        state_nxt = S_REQ;
                    end else begin
                        ins_nxt       = i_imem_rdata;
                        o_pc_nxt      = pc;
                        ins_valid_nxt = 1'b1;
                        state_nxt     = S_HOLD;
                    end
                end else if (i_redirect) begin
                    drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                // Redirect wins over a same-cycle handshake: no sequential advance.
                if (i_redirect) begin
                    pc_nxt        = redirect_tgt;
                    ins_valid_nxt = 1'b0;
                    state_nxt     = S_REQ;
                end else if (i_ins_ready) begin
                    pc_nxt        = pc_inc;
                    ins_valid_nxt = 1'b0;
                    state_nxt     = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            o_ins_valid <= 1'b0;
            o_ins       <= '0;
            o_pc        <= RESET_PC;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            drop        <= drop_nxt;
            o_ins_valid <= ins_valid_nxt;
            o_ins       <= ins_nxt;
            o_pc        <= o_pc_nxt;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then randomized traffic against an address-sequence model.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_ins_valid;
    logic        i_ins_ready;
    logic [31:0] o_ins;
    logic [31:0] o_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_ins_valid(o_ins_valid), .i_ins_ready(i_ins_ready),
        .o_ins(o_ins), .o_pc(o_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic idle_inputs();
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_redirect = 1'b0; i_redirect_pc = '0; i_ins_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge i_clk); i_rst = 1'b1; idle_inputs();
        @(negedge i_clk); #1;
        n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", o_imem_req); end
        n_checks++; if (o_ins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_ins_valid); end
        n_checks++; if (o_ins !== 32'h0) begin n_fail++; $display("FAIL rst_ins: got %h want 0", o_ins); end
        n_checks++; if (o_pc !== RST_PC) begin n_fail++; $display("FAIL rst_pc: got %h want %h", o_pc, RST_PC); end
        @(negedge i_clk); i_rst = 1'b0; #1;
        n_checks++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_first_req: got %b want 1", o_imem_req); end
        n_checks++; if (o_imem_addr !== RST_PC) begin n_fail++; $display("FAIL rst_first_addr: got %h want %h", o_imem_addr, RST_PC); end
    endtask

    // Grant one cycle after request, rvalid one cycle after grant.
    task automatic test_basic();
        @(negedge i_clk);
        n_checks++; if (o_imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req_hold: got %b want 1", o_imem_req); end
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0;
        n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req: got %b want 0", o_imem_req); end
        n_checks++; if (o_ins_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", o_ins_valid); end
        i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0093;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        n_checks++; if (o_ins_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", o_ins_valid); end
        n_checks++; if (o_ins !== 32'h0000_0093) begin n_fail++; $display("FAIL basic_ins: got %h want 00000093", o_ins); end
        n_checks++; if (o_pc !== RST_PC) begin n_fail++; $display("FAIL basic_pc: got %h want %h", o_pc, RST_PC); end
        i_ins_ready = 1'b1;
        @(negedge i_clk);
        i_ins_ready = 1'b0;
        n_checks++; if (o_ins_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %b want 0", o_ins_valid); end
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8000_0004) begin n_fail++; $display("FAIL basic_next_req: got req=%b addr=%h want 1 80000004", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_stall();
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0010_0113;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (o_ins_valid !== 1'b1 || o_ins !== 32'h0010_0113 || o_pc !== 32'h8000_0004) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b ins=%h pc=%h want 1 00100113 80000004", k, o_ins_valid, o_ins, o_pc); end
            n_checks++; if (o_imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_no_req%0d: got %b want 0", k, o_imem_req); end
            @(negedge i_clk);
        end
        i_ins_ready = 1'b1;
        @(negedge i_clk);
        i_ins_ready = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8000_0008) begin n_fail++; $display("FAIL stall_next_req: got req=%b addr=%h want 1 80000008", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_redirect_wait();
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_pc = 32'h8000_0103;
        @(negedge i_clk);
        i_redirect = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8000_0100) begin n_fail++; $display("FAIL rdw_req: got req=%b addr=%h want 1 80000100", o_imem_req, o_imem_addr); end
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (o_ins_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_dropped%0d: got %b want 0", k, o_ins_valid); end
            @(negedge i_clk);
        end
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0013;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        n_checks++; if (o_ins_valid !== 1'b1 || o_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL rdw_deliver: got v=%b pc=%h want 1 80000100", o_ins_valid, o_pc); end
        i_ins_ready = 1'b1;
        @(negedge i_clk);
        i_ins_ready = 1'b0;
    endtask

    task automatic test_redirect_ready();
        i_redirect = 1'b1; i_redirect_pc = 32'h8000_0010;
        @(negedge i_clk);
        i_redirect = 1'b0;
        n_checks++; if (o_imem_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL rdr_req_addr: got %h want 80000010", o_imem_addr); end
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0013;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        n_checks++; if (o_ins_valid !== 1'b1 || o_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL rdr_hold: got v=%b pc=%h want 1 80000010", o_ins_valid, o_pc); end
        i_redirect = 1'b1; i_redirect_pc = 32'h8000_0040; i_ins_ready = 1'b1;
        @(negedge i_clk);
        i_redirect = 1'b0; i_ins_ready = 1'b0;
        n_checks++; if (o_ins_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_cleared: got %b want 0", o_ins_valid); end
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h8000_0040) begin n_fail++; $display("FAIL rdr_next: got req=%b addr=%h want 1 80000040", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_wrap();
        i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
        @(negedge i_clk);
        i_redirect = 1'b0;
        n_checks++; if (o_imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h want fffffffc", o_imem_addr); end
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b1; i_imem_rdata = 32'h0000_0073;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        n_checks++; if (o_ins_valid !== 1'b1 || o_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_hold: got v=%b pc=%h want 1 fffffffc", o_ins_valid, o_pc); end
        i_ins_ready = 1'b1;
        @(negedge i_clk);
        i_ins_ready = 1'b0;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h want 1 00000000", o_imem_req, o_imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        i_imem_gnt = 1'b1;
        @(negedge i_clk);
        i_imem_gnt = 1'b0; i_rst = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_ins_valid !== 1'b0 || o_imem_req !== 1'b0) begin n_fail++; $display("FAIL rmw_in_reset: got v=%b req=%b want 0 0", o_ins_valid, o_imem_req); end
        i_rst = 1'b0; #1;
        n_checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== RST_PC) begin n_fail++; $display("FAIL rmw_first_req: got req=%b addr=%h want 1 %h", o_imem_req, o_imem_addr, RST_PC); end
        n_checks++; if (o_ins_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_valid: got %b want 0", o_ins_valid); end
    endtask

    // Model: the decoder must see the sequential address stream starting at the latest redirect target.
    task automatic test_random();
        logic [31:0] exp_pc, oaddr, tgt, s_addr;
        logic        outstanding, s_req, s_valid, redir, rdy, real_rv, gnt;
        int          lat, consumed;
        @(negedge i_clk); i_rst = 1'b1; idle_inputs();
        @(negedge i_clk);
        @(negedge i_clk); i_rst = 1'b0;
        exp_pc = RST_PC; outstanding = 1'b0; lat = 0; consumed = 0; oaddr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge i_clk);
            #1;
            s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_ins_valid;
            if (s_req) begin
                n_checks++; if (outstanding) begin n_fail++; $display("FAIL rand_one_outstanding cyc %0d: got req=1 want 0", cyc); end
            end
            if (s_valid) begin
                n_checks++; if (o_pc !== exp_pc || o_ins !== mem_word(exp_pc)) begin
                    n_fail++; $display("FAIL rand_ins cyc %0d: got pc=%h ins=%h want %h %h", cyc, o_pc, o_ins, exp_pc, mem_word(exp_pc)); end
            end
            redir   = ($urandom_range(99) < 4);
            tgt     = $urandom;
            rdy     = ($urandom_range(99) < 50);
            gnt     = s_req && ($urandom_range(99) < 60);
            real_rv = outstanding && (lat == 0);
            i_redirect = redir; i_redirect_pc = tgt; i_ins_ready = rdy; i_imem_gnt = gnt;
            if (real_rv) begin
                i_imem_rvalid = 1'b1; i_imem_rdata = mem_word(oaddr);
            end else if (!outstanding && $urandom_range(99) < 10) begin
                i_imem_rvalid = 1'b1; i_imem_rdata = $urandom;
            end else begin
                i_imem_rvalid = 1'b0; i_imem_rdata = '0;
            end
            if (s_req && !redir) begin
                n_checks++; if (s_addr !== exp_pc) begin n_fail++; $display("FAIL rand_req_addr cyc %0d: got %h want %h", cyc, s_addr, exp_pc); end
            end
            @(posedge i_clk);
            if (real_rv) outstanding = 1'b0;
            else if (outstanding) lat--;
            if (s_req && gnt) begin
                outstanding = 1'b1; lat = $urandom_range(2); oaddr = s_addr;
            end
            if (redir) exp_pc = {tgt[31:2], 2'b00};
            else if (s_valid && rdy) begin exp_pc = exp_pc + 32'd4; consumed++; end
        end
        @(negedge i_clk); idle_inputs();
        n_checks++; if (consumed < 100) begin n_fail++; $display("FAIL rand_progress: got %0d consumed want >= 100", consumed); end
    endtask

    initial begin
        i_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_ready();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
